// File: rtl/run_ctl_pkg.sv
// Shared encodings for the pipeline run-control unit.
package run_ctl_pkg;

   typedef enum logic [1:0] {
      ST_HALTED = 2'b00,
      ST_RUN    = 2'b01,
      ST_STEP   = 2'b10
   } run_state_t;

   typedef enum logic [1:0] {
      CMD_NOP  = 2'b00,
      CMD_RUN  = 2'b01,
      CMD_HALT = 2'b10,
      CMD_STEP = 2'b11
   } run_cmd_t;

   // Index width for n entries, never narrower than one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Run/halt button conditioning: 2-flop synchronizer, stability counter,
// one-cycle pulse on each debounced rising edge.
module btn_debounce #(
   parameter int unsigned DEB_W = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_press
);

   logic             btn_meta;
   logic             btn_sync;
   logic             btn_sync_d;
   logic             level;
   logic [DEB_W-1:0] cnt;

   // Level is accepted only after the synchronized input holds for the full count.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         btn_meta   <= 1'b0;
         btn_sync   <= 1'b0;
         btn_sync_d <= 1'b0;
         level      <= 1'b0;
         cnt        <= '0;
         o_press    <= 1'b0;
      end else begin
         btn_meta   <= i_btn;
         btn_sync   <= btn_meta;
         btn_sync_d <= btn_sync;
         o_press    <= 1'b0;
         if (btn_sync != btn_sync_d) begin
            cnt <= '0;
         end else if (cnt != {DEB_W{1'b1}}) begin
            cnt <= cnt + DEB_W'(1);
         end else if (btn_sync != level) begin
            level   <= btn_sync;
            o_press <= btn_sync;
         end
      end
   end

endmodule

// File: rtl/pipeline_run_ctl.sv
// Pipeline clock-enable generator: run/halt/step control, PC breakpoints,
// debounced button and enabled-cycle counter.
module pipeline_run_ctl
   import run_ctl_pkg::*;
#(
   parameter int unsigned PC_W   = 64,
   parameter int unsigned N_BP   = 4,
   parameter int unsigned STEP_W = 16,
   parameter int unsigned DEB_W  = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_btn,
   input  logic                       i_cmd_valid,
   input  logic [1:0]                 i_cmd,
   input  logic [STEP_W-1:0]          i_step_cnt,
   input  logic                       i_bp_wr,
   input  logic [clog2(N_BP)-1:0]     i_bp_idx,
   input  logic [PC_W-1:0]            i_bp_addr,
   input  logic                       i_bp_en,
   input  logic [PC_W-1:0]            i_pc_f,
   output logic                       o_clk_en,
   output logic [1:0]                 o_state,
   output logic                       o_bp_hit,
   output logic [clog2(N_BP)-1:0]     o_bp_idx,
   output logic [PC_W-1:0]            o_halt_pc,
   output logic [63:0]                o_cycle_cnt
);

   localparam int unsigned IDX_W = clog2(N_BP);

   run_state_t        state_q;
   run_state_t        state_d;
   run_cmd_t          cmd_c;
   logic [STEP_W-1:0] step_q;
   logic [STEP_W-1:0] step_d;
   logic [PC_W-1:0]   bp_addr_q [N_BP];
   logic [N_BP-1:0]   bp_en_q;
   logic              press;
   logic              bp_match_c;
   logic [IDX_W-1:0]  bp_sel_c;
   logic              hit_clr_c;

   btn_debounce #(
      .DEB_W (DEB_W)
   ) u_deb (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_btn   (i_btn),
      .o_press (press)
   );

   // Scan from the top down so the lowest matching channel wins.
   always_comb begin
      bp_match_c = 1'b0;
      bp_sel_c   = '0;
      for (int i = int'(N_BP) - 1; i >= 0; i--) begin
         if (bp_en_q[i] && (bp_addr_q[i] == i_pc_f)) begin
            bp_match_c = 1'b1;
            bp_sel_c   = IDX_W'(i);
         end
      end
   end

   // Next state: breakpoint beats command beats button; losers are dropped.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      hit_clr_c = 1'b0;
      cmd_c     = run_cmd_t'(i_cmd);
      if (state_q == ST_STEP) begin
         step_d = step_q - STEP_W'(1);
         if (step_q == STEP_W'(1)) state_d = ST_HALTED;
      end
      if (o_clk_en && bp_match_c) begin
         state_d = ST_HALTED;
      end else if (i_cmd_valid && (cmd_c != CMD_NOP)) begin
         case (cmd_c)
            CMD_RUN: begin
               state_d   = ST_RUN;
               hit_clr_c = 1'b1;
            end
            CMD_HALT: state_d = ST_HALTED;
            CMD_STEP: begin
               hit_clr_c = 1'b1;
               if (state_q == ST_HALTED) begin
                  state_d = ST_STEP;
                  step_d  = (i_step_cnt == '0) ? STEP_W'(1) : i_step_cnt;
               end
            end
            default: ;
         endcase
      end else if (press) begin
         if (state_q == ST_HALTED) begin
            state_d   = ST_RUN;
            hit_clr_c = 1'b1;
         end else begin
            state_d = ST_HALTED;
         end
      end
      if (state_d != ST_STEP) step_d = '0;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_HALTED;
         step_q      <= '0;
         o_clk_en    <= 1'b0;
         o_bp_hit    <= 1'b0;
         o_bp_idx    <= '0;
         o_halt_pc   <= '0;
         o_cycle_cnt <= '0;
         bp_en_q     <= '0;
         for (int i = 0; i < int'(N_BP); i++) bp_addr_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         o_clk_en <= (state_d != ST_HALTED);
         if (o_clk_en) o_cycle_cnt <= o_cycle_cnt + 64'd1;
         if (o_clk_en && bp_match_c) begin
            o_bp_hit  <= 1'b1;
            o_bp_idx  <= bp_sel_c;
            o_halt_pc <= i_pc_f;
         end else if (hit_clr_c) begin
            o_bp_hit <= 1'b0;
         end
         // Table writes land after any match already sampled this edge.
         if (i_bp_wr && (32'(i_bp_idx) < N_BP)) begin
            bp_addr_q[i_bp_idx] <= i_bp_addr;
            bp_en_q[i_bp_idx]   <= i_bp_en;
         end
      end
   end

   assign o_state = state_q;

endmodule
